// File: rtl/keypad_scan_debounce_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scan_debounce_pkg
//   Shared definitions for the keypad front end and the game-status FSM that
//   consumes its key events.
//   Contents:
//     pad_state_t  - 2-bit scanner state encoding (SCAN / DEBOUNCE / HOLD)
//     KEY_*        - key codes the game FSM maps to moves, as {row, col}
//     ROWS_IDLE    - row pattern with no key pulling any row low
//     single_low   - true when exactly one row line is low
//     low_index    - index of the low row line (meaningful with single_low)
// -----------------------------------------------------------------------------
package keypad_scan_debounce_pkg;

   // Scanner states. The numeric values are fixed so the game FSM and any
   // debug tap see the same codes.
   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HOLD     = 2'd2
   } pad_state_t;

   // Key codes are {row_idx[1:0], col_idx[1:0]} of the physical switch.
   localparam logic [3:0] KEY_DOWN   = 4'h9;
   localparam logic [3:0] KEY_LEFT   = 4'h4;
   localparam logic [3:0] KEY_RIGHT  = 4'h6;
   localparam logic [3:0] KEY_ROTATE = 4'h1;

   // Rows are pulled up, so an untouched column reads all ones.
   localparam logic [3:0] ROWS_IDLE = 4'b1111;

   // Counting the low lines lets the scanner reject ghosting and multi-key
   // chords on one column, where the row index would be ambiguous.
   function automatic logic single_low(input logic [3:0] rows);
      logic [2:0] zeros;
      zeros = 3'd0;
      for (int i = 0; i < 4; i++) begin
         zeros = zeros + {2'b00, ~rows[i]};
      end
      return (zeros == 3'd1);
   endfunction

   // Encodes the position of the low row. Only called once single_low has
   // confirmed there is exactly one such row.
   function automatic logic [1:0] low_index(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!rows[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scan_debounce_pad_sync.sv
// -----------------------------------------------------------------------------
// pad_sync
//   Two-flop synchronizer for a bus of independent, slowly changing inputs
//   (keypad rows). Each bit is synchronized on its own; there is no bus
//   coherency guarantee, which the debouncer downstream tolerates.
//   Ports:
//     clk    in   1      destination clock
//     rst_n  in   1      asynchronous, active-low reset; flops go to all ones
//     d      in   WIDTH  asynchronous input bus
//     q      out  WIDTH  synchronized output bus
// -----------------------------------------------------------------------------
module pad_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // First stage may go metastable; the second stage gives it a full cycle
   // to settle. Resetting to all ones matches the idle level of pulled-up rows
   // so no phantom key is seen while coming out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan_debounce.sv
// -----------------------------------------------------------------------------
// keypad_scan_debounce
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces the
//   found key and emits exactly one pad_pressed pulse per physical press.
//   Ports:
//     clk_40M      in   1  system clock
//     rst_n        in   1  asynchronous, active-low reset
//     pad_row      in   4  keypad rows, active low, asynchronous to clk_40M
//     pad_col      out  4  column drive, exactly one bit low
//     pad_key      out  4  last accepted key, {row_idx, col_idx}
//     pad_pressed  out  1  one-cycle pulse on an accepted press
//     pad_held     out  1  high from press acceptance to release acceptance
//   Parameters:
//     SCAN_DIV      cycles each column is driven before the rows are sampled
//     DEBOUNCE_CNT  consecutive stable cycles needed to accept press/release
// -----------------------------------------------------------------------------
module keypad_scan_debounce
   import keypad_scan_debounce_pkg::*;
#(
   parameter int SCAN_DIV     = 40000,
   parameter int DEBOUNCE_CNT = 400000
) (
   input  logic       clk_40M,
   input  logic       rst_n,
   input  logic [3:0] pad_row,
   output logic [3:0] pad_col,
   output logic [3:0] pad_key,
   output logic       pad_pressed,
   output logic       pad_held
);

   localparam int DIV_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
   localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

   pad_state_t       state;
   pad_state_t       state_next;

   logic [3:0]       rs;
   logic [1:0]       col_idx;
   logic [1:0]       col_next;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_next;
   logic [DEB_W-1:0] deb_cnt;
   logic [DEB_W-1:0] deb_next;
   logic [1:0]       row_idx;
   logic [1:0]       row_next;
   logic [3:0]       pattern;
   logic [3:0]       pattern_next;
   logic [3:0]       key_next;
   logic             pressed_next;
   logic             held_next;

   logic             div_done;
   logic             deb_done;
   logic             rows_match;
   logic             rows_idle;
   logic             one_low;

   pad_sync #(
      .WIDTH (4)
   ) u_row_sync (
      .clk   (clk_40M),
      .rst_n (rst_n),
      .d     (pad_row),
      .q     (rs)
   );

   // Terminal-count and row-pattern qualifiers shared by the next-state and
   // datapath logic, so both always agree on what the current cycle means.
   always_comb begin
      div_done   = (div_cnt == DIV_LAST);
      deb_done   = (deb_cnt == DEB_LAST);
      rows_match = (rs == pattern);
      rows_idle  = (rs == ROWS_IDLE);
      one_low    = single_low(rs);
   end

   // State register. Reset returns to scanning regardless of where the FSM
   // was, which also abandons any half-finished debounce.
   always_ff @(posedge clk_40M or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_SCAN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. SCAN only leaves when a column shows one clean key;
   // DEBOUNCE falls back to SCAN on any disagreement with the latched rows;
   // HOLD waits for a full stable release before scanning resumes.
   always_comb begin
      state_next = state;
      case (state)
         ST_SCAN: begin
            if (div_done && one_low) begin
               state_next = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (!rows_match) begin
               state_next = ST_SCAN;
            end else if (deb_done) begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (rows_idle && deb_done) begin
               state_next = ST_SCAN;
            end
         end
         default: begin
            state_next = ST_SCAN;
         end
      endcase
   end

   // Datapath and output next values. Counters only increment below their
   // terminal value, so they never wrap. The column only advances after an
   // empty/ambiguous sample or after a release, so a key under debounce or
   // hold keeps its own column driven. A failed debounce keeps the column and
   // restarts its dwell, giving the same key another chance on the next sample.
   always_comb begin
      col_next     = col_idx;
      div_next     = div_cnt;
      deb_next     = deb_cnt;
      row_next     = row_idx;
      pattern_next = pattern;
      key_next     = pad_key;
      pressed_next = 1'b0;
      held_next    = pad_held;
      case (state)
         ST_SCAN: begin
            if (div_done) begin
               div_next = '0;
               if (one_low) begin
                  row_next     = low_index(rs);
                  pattern_next = rs;
                  deb_next     = '0;
               end else begin
                  col_next = col_idx + 2'd1;
               end
            end else begin
               div_next = div_cnt + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (!rows_match) begin
               div_next = '0;
               deb_next = '0;
            end else if (deb_done) begin
               key_next     = {row_idx, col_idx};
               pressed_next = 1'b1;
               held_next    = 1'b1;
               deb_next     = '0;
            end else begin
               deb_next = deb_cnt + 1'b1;
            end
         end
         ST_HOLD: begin
            if (!rows_idle) begin
               deb_next = '0;
            end else if (deb_done) begin
               held_next = 1'b0;
               col_next  = col_idx + 2'd1;
               deb_next  = '0;
               div_next  = '0;
            end else begin
               deb_next = deb_cnt + 1'b1;
            end
         end
         default: begin
            deb_next = '0;
            div_next = '0;
         end
      endcase
   end

   // Datapath and output registers. pad_col is registered from the next
   // column index so the drive and col_idx always change on the same edge.
   always_ff @(posedge clk_40M or negedge rst_n) begin
      if (!rst_n) begin
         col_idx     <= 2'd0;
         div_cnt     <= '0;
         deb_cnt     <= '0;
         row_idx     <= 2'd0;
         pattern     <= ROWS_IDLE;
         pad_col     <= 4'b1110;
         pad_key     <= 4'h0;
         pad_pressed <= 1'b0;
         pad_held    <= 1'b0;
      end else begin
         col_idx     <= col_next;
         div_cnt     <= div_next;
         deb_cnt     <= deb_next;
         row_idx     <= row_next;
         pattern     <= pattern_next;
         pad_col     <= ~(4'b0001 << col_next);
         pad_key     <= key_next;
         pad_pressed <= pressed_next;
         pad_held    <= held_next;
      end
   end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_debounce
//   Drives a modelled 4x4 switch matrix into keypad_scan_debounce with short
//   scan/debounce periods. Each intended press pushes its key code into a
//   queue; a monitor pops one entry per pad_pressed pulse.
// -----------------------------------------------------------------------------
module tb_keypad_scan_debounce;
   import keypad_scan_debounce_pkg::*;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;

   logic        clk_40M = 1'b0;
   logic        rst_n   = 1'b0;
   logic [3:0]  pad_row;
   logic [3:0]  pad_col;
   logic [3:0]  pad_key;
   logic        pad_pressed;
   logic        pad_held;

   logic [15:0] keys = '0;
   logic [3:0]  exp_q[$];
   logic [3:0]  exp_key;
   logic [3:0]  exp_col;
   logic [3:0]  col_seen;
   int          n_checks = 0;
   int          n_fail   = 0;

   keypad_scan_debounce #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .clk_40M     (clk_40M),
      .rst_n       (rst_n),
      .pad_row     (pad_row),
      .pad_col     (pad_col),
      .pad_key     (pad_key),
      .pad_pressed (pad_pressed),
      .pad_held    (pad_held)
   );

   // 40 MHz nominal; the actual period is irrelevant to the logic.
   always #5 clk_40M = ~clk_40M;

   // Switch matrix: a closed switch at (r,c) pulls row r low while column c
   // is driven low; otherwise the pull-ups win.
   always_comb begin
      pad_row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !pad_col[c]) begin
               pad_row[r] = 1'b0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_40M);
   endtask

   // One press with optional contact bounce on both edges. The press is long
   // enough to be found from any scan position, and the release long enough
   // to be accepted, so each call owes exactly one pulse carrying key.
   task automatic applyStimulus(input logic [3:0] key, input int press_bounce,
                                input int hold_cycles, input int release_cycles);
      int rel_bounce;
      keys = '0;
      for (int i = 0; i < press_bounce; i++) begin
         keys[key] = (i % 2 == 0);
         cycles($urandom_range(1, 3));
      end
      keys[key] = 1'b1;
      exp_q.push_back(key);
      cycles(hold_cycles);
      checkOutput("pulse_seen", exp_q.size(), 0);
      checkOutput("held_while_pressed", {31'd0, pad_held}, 1);
      checkOutput("key_while_pressed", {28'd0, pad_key}, {28'd0, key});
      rel_bounce = $urandom_range(0, 4);
      for (int i = 0; i < rel_bounce; i++) begin
         keys[key] = (i % 2 == 1);
         cycles($urandom_range(1, 3));
      end
      keys = '0;
      cycles(release_cycles);
      checkOutput("held_after_release", {31'd0, pad_held}, 0);
      exp_q.delete();
   endtask

   // Scoreboard monitor: every pulse must match the oldest owed key.
   always @(negedge clk_40M) begin
      if (rst_n && pad_pressed === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_pulse: got key 0x%0h, required no pulse", pad_key);
         end else begin
            exp_key = exp_q.pop_front();
            checkOutput("pulse_key", {28'd0, pad_key}, {28'd0, exp_key});
            checkOutput("held_at_pulse", {31'd0, pad_held}, 1);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      keys  = '0;
      rst_n = 1'b0;
      cycles(3);

      $display("[TB] reset state");
      checkOutput("reset_col", {28'd0, pad_col}, 32'h0000_000E);
      checkOutput("reset_key", {28'd0, pad_key}, 0);
      checkOutput("reset_pressed", {31'd0, pad_pressed}, 0);
      checkOutput("reset_held", {31'd0, pad_held}, 0);

      $display("[TB] idle scan");
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge clk_40M);
         exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
         checkOutput("idle_col", {28'd0, pad_col}, {28'd0, exp_col});
      end

      $display("[TB] stable press KEY_DOWN");
      keys[KEY_DOWN] = 1'b1;
      exp_q.push_back(KEY_DOWN);
      cycles(60);
      checkOutput("down_pulse_seen", exp_q.size(), 0);
      checkOutput("down_held", {31'd0, pad_held}, 1);
      keys = '0;
      cycles(DEBOUNCE_CNT + 1);
      checkOutput("down_held_before_release", {31'd0, pad_held}, 1);
      cycles(1);
      checkOutput("down_released", {31'd0, pad_held}, 0);
      checkOutput("down_next_col", {28'd0, pad_col}, 32'h0000_000B);
      checkOutput("down_key_kept", {28'd0, pad_key}, {28'd0, KEY_DOWN});

      $display("[TB] bouncing press key 0");
      cycles(20);
      for (int i = 0; i < 8; i++) begin
         keys[0] = (i % 2 == 0);
         cycles(3);
      end
      keys[0] = 1'b1;
      exp_q.push_back(4'h0);
      cycles(60);
      checkOutput("bounce_pulse_seen", exp_q.size(), 0);
      checkOutput("bounce_key", {28'd0, pad_key}, 0);
      keys = '0;
      cycles(30);
      checkOutput("bounce_released", {31'd0, pad_held}, 0);

      $display("[TB] ghost keys on column 2");
      keys[1*4+2] = 1'b1;
      keys[3*4+2] = 1'b1;
      col_seen = 4'h0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_40M);
         col_seen = col_seen | ~pad_col;
      end
      checkOutput("ghost_cols_visited", {28'd0, col_seen}, 32'h0000_000F);
      checkOutput("ghost_held", {31'd0, pad_held}, 0);
      keys = '0;
      cycles(10);

      $display("[TB] repeated KEY_RIGHT");
      applyStimulus(KEY_RIGHT, 0, 1000, 40);
      applyStimulus(KEY_RIGHT, 0, 100, 40);

      $display("[TB] random presses");
      for (int n = 0; n < 12; n++) begin
         applyStimulus(4'($urandom_range(0, 15)), $urandom_range(0, 6),
                       $urandom_range(40, 200), $urandom_range(20, 60));
      end

      $display("[TB] reset during hold");
      keys[KEY_RIGHT] = 1'b1;
      exp_q.push_back(KEY_RIGHT);
      cycles(50);
      checkOutput("hold_pulse_seen", exp_q.size(), 0);
      checkOutput("hold_held", {31'd0, pad_held}, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("hold_rst_col", {28'd0, pad_col}, 32'h0000_000E);
      checkOutput("hold_rst_held", {31'd0, pad_held}, 0);
      checkOutput("hold_rst_key", {28'd0, pad_key}, 0);
      keys = '0;
      cycles(3);
      rst_n = 1'b1;
      cycles(40);

      $display("[TB] reset during debounce");
      rst_n = 1'b0;
      cycles(2);
      keys[0] = 1'b1;
      rst_n   = 1'b1;
      cycles(8);
      rst_n = 1'b0;
      #1;
      checkOutput("deb_rst_col", {28'd0, pad_col}, 32'h0000_000E);
      checkOutput("deb_rst_held", {31'd0, pad_held}, 0);
      checkOutput("deb_rst_key", {28'd0, pad_key}, 0);
      keys = '0;
      cycles(3);
      rst_n = 1'b1;
      cycles(40);

      checkOutput("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
